// File: rtl/gate_pkg.sv
// Shared definitions for the two-input gate library self-test: gate codes,
// the gate select type and the checker state encoding.
package gate_pkg;

   typedef logic [2:0] gate_sel_t;

   localparam gate_sel_t GATE_AND     = 3'd0;
   localparam gate_sel_t GATE_OR      = 3'd1;
   localparam gate_sel_t GATE_NOT     = 3'd2;
   localparam gate_sel_t GATE_NAND    = 3'd3;
   localparam gate_sel_t GATE_NOR     = 3'd4;
   localparam gate_sel_t GATE_XOR     = 3'd5;
   localparam gate_sel_t GATE_XNOR    = 3'd6;
   localparam gate_sel_t GATE_ILLEGAL = 3'd7;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/gate_ref_model.sv
// Combinational expected-output model for every gate in the library; the one
// place that defines what each gate code should produce for a given A/B.
module gate_ref_model (
   input  logic [2:0] gate_sel,
   input  logic       a,
   input  logic       b,
   output logic       y_exp
);
   import gate_pkg::*;

   // NOT ignores B; the illegal code never reaches a comparison.
   always_comb begin
      y_exp = 1'b0;
      case (gate_sel)
         GATE_AND:  y_exp = a & b;
         GATE_OR:   y_exp = a | b;
         GATE_NOT:  y_exp = ~a;
         GATE_NAND: y_exp = ~(a & b);
         GATE_NOR:  y_exp = ~(a | b);
         GATE_XOR:  y_exp = a ^ b;
         GATE_XNOR: y_exp = ~(a ^ b);
         default:   y_exp = 1'b0;
      endcase
   end

endmodule

// File: rtl/gate_truth_table_checker.sv
// Sweeps AB = 00,01,10,11 into a gate under test, samples Y after a settle
// interval per vector and reports per-vector mismatches plus an overall pass.
module gate_truth_table_checker #(
   parameter int SETTLE_CYCLES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       start,
   input  logic [2:0] gate_sel,
   output logic       drive_a,
   output logic       drive_b,
   input  logic       dut_y,
   output logic       busy,
   output logic       done,
   output logic       pass,
   output logic [3:0] fail_mask,
   output logic       illegal
);
   import gate_pkg::*;

   localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

   state_t           state_q;
   gate_sel_t        sel_q;
   logic [1:0]       vec_q;
   logic [CNT_W-1:0] cnt_q;
   logic             drive_a_q, drive_b_q;
   logic             busy_q, done_q, pass_q, illegal_q;
   logic [3:0]       fail_mask_q, fail_mask_d;
   logic             yExp;

   gate_ref_model u_ref (
      .gate_sel (sel_q),
      .a        (vec_q[1]),
      .b        (vec_q[0]),
      .y_exp    (yExp)
   );

   // Mask as it will stand once the current vector's sample is folded in.
   always_comb begin
      fail_mask_d = fail_mask_q;
      if (dut_y != yExp) fail_mask_d[vec_q] = 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         sel_q       <= GATE_AND;
         vec_q       <= 2'd0;
         cnt_q       <= '0;
         drive_a_q   <= 1'b0;
         drive_b_q   <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         pass_q      <= 1'b0;
         illegal_q   <= 1'b0;
         fail_mask_q <= 4'h0;
      end else begin
         case (state_q)
            IDLE: begin
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               drive_a_q <= 1'b0;
               drive_b_q <= 1'b0;
               if (start) begin
                  sel_q       <= gate_sel;
                  vec_q       <= 2'd0;
                  cnt_q       <= '0;
                  busy_q      <= 1'b1;
                  pass_q      <= 1'b0;
                  illegal_q   <= 1'b0;
                  fail_mask_q <= 4'h0;
                  if (gate_sel == GATE_ILLEGAL) begin
                     state_q     <= DONE;
                     done_q      <= 1'b1;
                     illegal_q   <= 1'b1;
                     fail_mask_q <= 4'hF;
                  end else begin
                     state_q <= SETTLE;
                  end
               end
            end

            SETTLE: begin
               if (cnt_q == CNT_LAST) begin
                  fail_mask_q <= fail_mask_d;
                  if (vec_q == 2'd3) begin
                     state_q <= DONE;
                     done_q  <= 1'b1;
                     pass_q  <= (fail_mask_d == 4'h0);
                  end else begin
                     vec_q     <= vec_q + 2'd1;
                     cnt_q     <= '0;
                     drive_a_q <= (vec_q + 2'd1) >> 1 != 2'd0;
                     drive_b_q <= ~vec_q[0];
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end

            // Drives hold vector 3 through this cycle, then drop in IDLE.
            DONE: begin
               state_q   <= IDLE;
               done_q    <= 1'b0;
               busy_q    <= 1'b0;
               drive_a_q <= 1'b0;
               drive_b_q <= 1'b0;
            end

            default: state_q <= IDLE;
         endcase
      end
   end

   assign drive_a   = drive_a_q;
   assign drive_b   = drive_b_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign pass      = pass_q;
   assign fail_mask = fail_mask_q;
   assign illegal   = illegal_q;

endmodule

// File: tb/tb_gate_truth_table_checker.sv
// Bench for gate_truth_table_checker: two instances (settle 2 and settle 1)
// driving behavioural gates, checked against a truth-table reference.
module tb_gate_truth_table_checker;

   logic       clk;
   logic       rst;
   logic       start     [2];
   logic [2:0] gateSel   [2];
   logic       driveA    [2];
   logic       driveB    [2];
   logic       dutY      [2];
   logic       busy      [2];
   logic       done      [2];
   logic       pass      [2];
   logic [3:0] failMask  [2];
   logic       illegal   [2];
   logic [2:0] gutCode   [2];

   int checks = 0;
   int errors = 0;
   int settleOf [2];

   gate_truth_table_checker #(.SETTLE_CYCLES(2)) dut0 (
      .clk(clk), .rst(rst), .start(start[0]), .gate_sel(gateSel[0]),
      .drive_a(driveA[0]), .drive_b(driveB[0]), .dut_y(dutY[0]),
      .busy(busy[0]), .done(done[0]), .pass(pass[0]),
      .fail_mask(failMask[0]), .illegal(illegal[0])
   );

   gate_truth_table_checker #(.SETTLE_CYCLES(1)) dut1 (
      .clk(clk), .rst(rst), .start(start[1]), .gate_sel(gateSel[1]),
      .drive_a(driveA[1]), .drive_b(driveB[1]), .dut_y(dutY[1]),
      .busy(busy[1]), .done(done[1]), .pass(pass[1]),
      .fail_mask(failMask[1]), .illegal(illegal[1])
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Truth table as a 4-bit column, bit v holds Y for A=v[1], B=v[0].
   function automatic logic [3:0] truthOf(input logic [2:0] code);
      logic [3:0] tt;
      case (code)
         3'd0:    tt = 4'b1000;
         3'd1:    tt = 4'b1110;
         3'd2:    tt = 4'b0011;
         3'd3:    tt = 4'b0111;
         3'd4:    tt = 4'b0001;
         3'd5:    tt = 4'b0110;
         3'd6:    tt = 4'b1001;
         default: tt = 4'b0000;
      endcase
      return tt;
   endfunction

   always_comb begin
      logic [3:0] t0, t1;
      t0 = truthOf(gutCode[0]);
      t1 = truthOf(gutCode[1]);
      dutY[0] = t0[{driveA[0], driveB[0]}];
      dutY[1] = t1[{driveA[1], driveB[1]}];
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkIdle(input int d, input logic expPass, input logic [3:0] expMask,
                            input logic expIll);
      checkOutput($sformatf("idle_busy%0d", d), 32'(busy[d]), 32'd0);
      checkOutput($sformatf("idle_done%0d", d), 32'(done[d]), 32'd0);
      checkOutput($sformatf("idle_drive%0d", d), {30'd0, driveA[d], driveB[d]}, 32'd0);
      checkOutput($sformatf("held_pass%0d", d), 32'(pass[d]), 32'(expPass));
      checkOutput($sformatf("held_mask%0d", d), 32'(failMask[d]), 32'(expMask));
      checkOutput($sformatf("held_illegal%0d", d), 32'(illegal[d]), 32'(expIll));
   endtask

   // Entered at cycle 1 after accept; returns at the done cycle.
   task automatic followSweep(input int d, input logic [2:0] sel, input logic [2:0] gut,
                              output logic expPass, output logic [3:0] expMask);
      int s;
      int v;
      s = settleOf[d];
      if (sel == 3'd7) begin
         expMask = 4'hF;
         expPass = 1'b0;
         checkOutput("ill_busy", 32'(busy[d]), 32'd1);
         checkOutput("ill_done", 32'(done[d]), 32'd1);
         checkOutput("ill_drive", {30'd0, driveA[d], driveB[d]}, 32'd0);
         checkOutput("ill_flag", 32'(illegal[d]), 32'd1);
         checkOutput("ill_mask", 32'(failMask[d]), 32'hF);
         checkOutput("ill_pass", 32'(pass[d]), 32'd0);
         return;
      end
      expMask = truthOf(sel) ^ truthOf(gut);
      expPass = (expMask == 4'h0);
      for (int c = 1; c <= 4 * s + 1; c++) begin
         v = (c <= 4 * s) ? (c - 1) / s : 3;
         checkOutput($sformatf("busy_c%0d", c), 32'(busy[d]), 32'd1);
         checkOutput($sformatf("done_c%0d", c), 32'(done[d]), 32'(c == 4 * s + 1));
         checkOutput($sformatf("drive_c%0d", c), {30'd0, driveA[d], driveB[d]}, 32'(v));
         if (c == 1) begin
            checkOutput("cleared_pass", 32'(pass[d]), 32'd0);
            checkOutput("cleared_ill", 32'(illegal[d]), 32'd0);
            checkOutput("cleared_mask", 32'(failMask[d]), 32'd0);
         end
         if (c < 4 * s + 1) tick();
      end
      checkOutput("done_pass", 32'(pass[d]), 32'(expPass));
      checkOutput("done_mask", 32'(failMask[d]), 32'(expMask));
      checkOutput("done_illegal", 32'(illegal[d]), 32'd0);
   endtask

   task automatic applyStimulus(input int d, input logic [2:0] sel, input logic [2:0] gut);
      logic       ep;
      logic [3:0] em;
      gateSel[d] = sel;
      gutCode[d] = gut;
      start[d]   = 1'b1;
      tick();
      start[d] = 1'b0;
      followSweep(d, sel, gut, ep, em);
      tick();
      checkIdle(d, ep, em, sel == 3'd7);
      tick();
      checkIdle(d, ep, em, sel == 3'd7);
   endtask

   initial begin
      logic       ep;
      logic [3:0] em;
      logic [2:0] rsel, rgut;
      int         rd;

      settleOf[0] = 2;
      settleOf[1] = 1;
      rst = 1'b1;
      for (int d = 0; d < 2; d++) begin
         start[d]   = 1'b0;
         gateSel[d] = 3'd0;
         gutCode[d] = 3'd0;
      end
      tick();
      tick();
      for (int d = 0; d < 2; d++) checkIdle(d, 1'b0, 4'h0, 1'b0);
      rst = 1'b0;
      tick();

      $display("[TB] AND sweep, faulty XOR, illegal code");
      applyStimulus(0, 3'd0, 3'd0);
      applyStimulus(0, 3'd5, 3'd1);
      applyStimulus(0, 3'd7, 3'd0);

      $display("[TB] reset mid-sweep");
      gateSel[0] = 3'd6;
      gutCode[0] = 3'd6;
      start[0]   = 1'b1;
      tick();
      start[0] = 1'b0;
      tick();
      tick();
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      checkIdle(0, 1'b0, 4'h0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         checkOutput("no_done_after_rst", 32'(done[0]), 32'd0);
         tick();
      end
      applyStimulus(0, 3'd6, 3'd6);

      $display("[TB] start held across sweep");
      gateSel[0] = 3'd5;
      gutCode[0] = 3'd5;
      start[0]   = 1'b1;
      tick();
      gateSel[0] = 3'd0;
      followSweep(0, 3'd5, 3'd5, ep, em);
      tick();
      checkIdle(0, ep, em, 1'b0);
      tick();
      start[0] = 1'b0;
      followSweep(0, 3'd0, 3'd5, ep, em);
      tick();
      checkIdle(0, ep, em, 1'b0);

      $display("[TB] fast settle NOT and NOR");
      applyStimulus(1, 3'd2, 3'd2);
      applyStimulus(1, 3'd4, 3'd4);

      $display("[TB] random sweeps");
      for (int i = 0; i < 16; i++) begin
         rd   = int'($urandom_range(0, 1));
         rsel = 3'($urandom_range(0, 7));
         rgut = (rsel != 3'd7 && $urandom_range(0, 1) == 1) ? rsel : 3'($urandom_range(0, 6));
         applyStimulus(rd, rsel, rgut);
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
